cnt_bcd_converter: RTL and testbench
====================================

Name: cnt_bcd_converter

Overview:
- Downstream consumer of the signed up/down counter output.
- Converts a signed two's-complement counter value into a sign flag plus packed BCD digits for the display/readout stage.
- Iterative double-dabble engine (shift-and-add-3), one bit per clock.
- valid/ready handshake on both input and output, so it can be driven every cycle or sparsely, and can be back-pressured by the display.

Parameters:
- WIDTH, 10, bit width of the signed input; equals counter output width.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^(WIDTH-1); default covers magnitudes 0..512.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  converter can accept a value; high only in IDLE.
- in_data  input  WIDTH  signed two's-complement value to convert, e.g. counter cnt.
- out_valid  output  1  out_sign/out_bcd hold a completed conversion.
- out_ready  input  1  downstream accepts the result.
- out_sign  output  1  1 = negative input, 0 = zero or positive.
- out_bcd  output  4*DIGITS  packed BCD, most significant digit in MSBs.

Behaviour:
- Reset is synchronous and active-high, on clock clk.
  - At rst edge: state=IDLE, out_valid=0, out_sign=0, out_bcd=0, internal iteration counter=0.
  - in_ready reads 1 from the first cycle after reset.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1, capture sign = in_data[WIDTH-1] and magnitude = |in_data| as WIDTH-bit unsigned.
  - -2^(WIDTH-1) gives magnitude 2^(WIDTH-1) with no overflow.
  - Clear the working BCD register and the iteration counter, then go to CONVERT.
- CONVERT:
  - in_ready=0.
  - Each edge: every working digit >= 5 gets +3; then the {bcd, magnitude} register shifts left one bit, magnitude MSB entering bcd LSB.
  - After exactly WIDTH iterations, copy working BCD to out_bcd and captured sign to out_sign, then go to DONE.
  - Sign forced to 0 when the magnitude is 0 (no negative zero).
- DONE:
  - out_valid=1, in_ready=0.
  - On an edge with out_ready=1, go to IDLE.
  - Otherwise hold, with out_sign/out_bcd stable.
- Latency: out_valid rises WIDTH edges after the accepting edge (10 by default). Minimum period between accepts is WIDTH+2 cycles.
- out_sign/out_bcd change only on the edge entering DONE. They are stable through CONVERT and retain the last result after the handshake, so the display holds the value.
- in_valid/in_data are ignored while not in IDLE; no queueing.
- out_ready is ignored outside DONE.
- Reset mid-CONVERT or in DONE: conversion is discarded, no out_valid pulse, outputs cleared to 0.
- Simultaneous in_valid in the same cycle as the DONE handshake: not accepted. It is accepted on the next edge from IDLE.

Test Plan:
- rst 1 cycle, then in_data=17 with in_valid=1 -> in_ready=0 next cycle; out_valid=1 exactly 10 edges after accept; out_sign=0, out_bcd=0x017.
- Counter boundaries: in_data=269 -> sign 0, bcd 0x269. in_data=-263 -> sign 1, bcd 0x263. in_data=-51 -> sign 1, bcd 0x051.
- Extremes: in_data=-512 -> sign 1, bcd 0x512. in_data=511 -> sign 0, bcd 0x511. in_data=0 -> sign 0, bcd 0x000.
- Back-pressure: hold out_ready=0 for 6 cycles in DONE -> out_valid stays 1, outputs unchanged, in_ready=0, in_valid pulses ignored. Raise out_ready -> IDLE next edge, then a new accept is possible.
- Reset mid-CONVERT (rst at iteration 4 of converting 100) -> out_valid never asserts, out_bcd=0, in_ready=1 the cycle after rst deasserts.
- Random regression: 1000 random signed 10-bit values with random out_ready stalls -> every result matches the reference decimal conversion, and no input is accepted while busy.

Source files
------------

// File: rtl/cnt_bcd_converter.sv
// Signed two's-complement to sign + packed BCD converter.
// Iterative double-dabble: one magnitude bit is consumed per clock in CONVERT,
// with valid/ready handshakes on both sides so the display can back-pressure.
module cnt_bcd_converter #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [4*DIGITS-1:0]   out_bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] mag;
    logic [BW-1:0]    bcd_work;
    logic             sign_cap;
    logic [CW-1:0]    iter;

    logic [BW-1:0]       bcd_adj;
    logic [BW+WIDTH-1:0] shifted;
    logic [BW-1:0]       bcd_next;
    logic [WIDTH-1:0]    mag_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Add-3 correction on every working digit that would overflow past 9 when doubled
    always_comb begin
        bcd_adj = bcd_work;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
        end
    end

    // Shift the combined {bcd, magnitude} register; magnitude MSB feeds the BCD LSB
    always_comb begin
        shifted  = {bcd_adj, mag} << 1;
        bcd_next = shifted[BW+WIDTH-1:WIDTH];
        mag_next = shifted[WIDTH-1:0];
    end

    // Control FSM and datapath; results only move to the outputs on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mag      <= '0;
            bcd_work <= '0;
            sign_cap <= 1'b0;
            iter     <= '0;
            out_sign <= 1'b0;
            out_bcd  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_cap <= in_data[WIDTH-1];
                        // Most negative value maps to 2^(WIDTH-1), still representable unsigned
                        mag      <= in_data[WIDTH-1] ? (~in_data) + WIDTH'(1) : in_data;
                        bcd_work <= '0;
                        iter     <= '0;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd_work <= bcd_next;
                    mag      <= mag_next;
                    iter     <= iter + CW'(1);
                    if (iter == CW'(WIDTH - 1)) begin
                        out_bcd  <= bcd_next;
                        // Zero magnitude never reports as negative
                        out_sign <= sign_cap && (bcd_next != '0);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_bcd_converter.sv
// Self-checking bench for cnt_bcd_converter: directed scenarios plus a random
// regression against a decimal-arithmetic reference model.
module tb_cnt_bcd_converter;

    localparam int WIDTH  = 10;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_sign;
    logic [BW-1:0]    out_bcd;

    int total = 0;
    int bad   = 0;

    // last completed result, which the outputs must keep holding
    logic [BW-1:0] prev_bcd  = '0;
    logic          prev_sign = 1'b0;

    cnt_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_bcd   (out_bcd)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: decimal digits of |v| packed as BCD
    function automatic logic [BW-1:0] ref_bcd(input int v);
        int m;
        logic [BW-1:0] r;
        m = (v < 0) ? -v : v;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // One full transaction: accept, convert, optional stall in DONE, handshake.
    // With noise set, in_valid/in_data/out_ready are randomized while busy.
    task automatic run_one(input string name, input int v, input int stall, input bit noise);
        logic [BW-1:0] exp_bcd;
        logic          exp_sign;
        int            lat;
        bit            stable;
        exp_bcd  = ref_bcd(v);
        exp_sign = (v < 0);
        stable   = 1'b1;

        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_before_accept got=%b want=1", name, in_ready);
        end
        in_data  = WIDTH'(v);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_ready got=%b want=0", name, in_ready);
        end

        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (noise) begin
                in_valid  = 1'($urandom);
                in_data   = WIDTH'($urandom);
                out_ready = 1'($urandom);
            end
            if (out_bcd !== prev_bcd || out_sign !== prev_sign || in_ready !== 1'b0) stable = 1'b0;
            step();
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        total++;
        if (lat != WIDTH) begin
            bad++;
            $display("FAIL %s latency got=%0d want=%0d", name, lat, WIDTH);
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL %s hold_during_convert got=changed want=bcd %h sign %b", name, prev_bcd, prev_sign);
        end
        total++;
        if (out_bcd !== exp_bcd || out_sign !== exp_sign) begin
            bad++;
            $display("FAIL %s result v=%0d got=%b/%h want=%b/%h", name, v, out_sign, out_bcd, exp_sign, exp_bcd);
        end

        for (int s = 0; s < stall; s++) begin
            in_valid = noise ? 1'($urandom) : 1'b1;
            in_data  = WIDTH'($urandom);
            step();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== exp_bcd || out_sign !== exp_sign) begin
                bad++;
                $display("FAIL %s stall%0d got=v%b r%b %b/%h want=v1 r0 %b/%h",
                         name, s, out_valid, in_ready, out_sign, out_bcd, exp_sign, exp_bcd);
            end
        end

        // in_valid on the handshake edge must not be accepted
        in_valid  = 1'b1;
        in_data   = WIDTH'($urandom);
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== exp_bcd || out_sign !== exp_sign) begin
            bad++;
            $display("FAIL %s handshake got=r%b v%b %b/%h want=r1 v0 %b/%h",
                     name, in_ready, out_valid, out_sign, out_bcd, exp_sign, exp_bcd);
        end
        prev_bcd  = exp_bcd;
        prev_sign = exp_sign;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sign !== 1'b0 || out_bcd !== '0) begin
            bad++;
            $display("FAIL reset_state got=r%b v%b s%b bcd=%h want=r1 v0 s0 bcd=000",
                     in_ready, out_valid, out_sign, out_bcd);
        end
        prev_bcd  = '0;
        prev_sign = 1'b0;
    endtask

    task automatic test_basic();
        run_one("basic17", 17, 0, 1'b0);
    endtask

    task automatic test_boundaries();
        int vals[6] = '{269, -263, -51, -512, 511, 0};
        foreach (vals[i]) run_one("boundary", vals[i], 0, 1'b0);
    endtask

    task automatic test_back_pressure();
        run_one("bp_a", -345, 6, 1'b0);
        run_one("bp_b", 88, 0, 1'b0);
    endtask

    task automatic test_reset_mid_convert();
        bit saw_valid;
        in_data  = WIDTH'(100);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== '0 || out_sign !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got=r%b v%b s%b bcd=%h want=r1 v0 s0 bcd=000",
                     in_ready, out_valid, out_sign, out_bcd);
        end
        saw_valid = 1'b0;
        repeat (15) begin
            step();
            if (out_valid === 1'b1) saw_valid = 1'b1;
        end
        total++;
        if (saw_valid) begin
            bad++;
            $display("FAIL mid_reset_no_valid got=pulse want=none");
        end
        prev_bcd  = '0;
        prev_sign = 1'b0;
        run_one("after_reset", -7, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 1000; n++) begin
            int v;
            v = int'($urandom_range(1023, 0)) - 512;
            run_one("random", v, int'($urandom_range(3, 0)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_back_pressure();
        test_reset_mid_convert();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
